// File: rtl/seqdet_pkg.sv
// Shared types for the arbitrated serial pattern detector: top FSM states,
// detector state encoding and the generic next-state function.
package seqdet_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_e;

  localparam logic [3:0] PAT_DEFAULT = 4'b1011;

  // Detector state = number of pattern bits matched so far.
  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S10  = 2'd2;
  localparam logic [1:0] S101 = 2'd3;

  // Longest proper suffix of (matched prefix + x) that is again a pattern prefix.
  function automatic logic [1:0] det_next(input logic [1:0] k, input logic x,
                                          input logic [3:0] pat);
    logic [3:0] sv;
    logic [3:0] m;
    logic [1:0] best;
    sv   = 4'((pat >> (4 - int'(k))) << 1) | {3'b000, x};
    best = S0;
    for (int l = 1; l <= 3; l++) begin
      m = 4'((1 << l) - 1);
      if (l <= int'(k) + 1 && ((sv & m) == (pat >> (4 - l))))
        best = 2'(l);
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial overlapping Mealy detector for a 4-bit pattern, with a
// synchronous clear so each job starts from a clean state.
module seq_det_core
  import seqdet_pkg::*;
#(
  parameter logic [3:0] PAT = PAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic y
);

  logic [1:0] st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (clr)     st_d = S0;
    else if (en) st_d = det_next(st_q, x, PAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= S0;
    else        st_q <= st_d;
  end

  assign y = (st_q == S101) && (x == PAT[0]);

endmodule

// File: rtl/seqdet_arbiter.sv
// Round-robin scheduler sharing one serial detector between two word
// producers: grant, shift the word MSB-first, report the hit count.
module seqdet_arbiter
  import seqdet_pkg::*;
#(
  parameter int         W   = 8,
  parameter logic [3:0] PAT = PAT_DEFAULT,
  parameter int         HW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          ser_x,
  output logic          det_y,
  output logic          done,
  output logic          owner,
  output logic [HW-1:0] hits
);

  localparam int CW = $clog2(W);

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            det_clr, det_en, core_y;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    hits_d  = hits_q;
    owner_d = owner_q;
    last_d  = last_q;
    det_clr = 1'b0;
    det_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = LOAD;
          // On a tie serve whoever was not served last.
          owner_d = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      LOAD: begin
        state_d = SHIFT;
        shift_d = owner_q ? data1 : data0;
        cnt_d   = CW'(W - 1);
        hits_d  = '0;
        det_clr = 1'b1;
        last_d  = owner_q;
      end
      SHIFT: begin
        det_en  = 1'b1;
        if (core_y && hits_q != '1) hits_d = hits_q + 1'b1;
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      hits_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // so the first tie goes to requester 0
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  seq_det_core #(.PAT(PAT)) u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (det_clr),
    .en   (det_en),
    .x    (ser_x),
    .y    (core_y)
  );

  assign gnt   = (state_q == LOAD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == REPORT);
  assign ser_x = (state_q == SHIFT) & shift_q[W-1];
  assign det_y = (state_q == SHIFT) & core_y;
  assign owner = owner_q;
  assign hits  = hits_q;

endmodule
